// File: rtl/lzd48_arbiter_if.sv
// Request, result and detector signal bundle for lzd48_arbiter.
// res0_norm/res1_norm are present only when LZDARB_NORM_EN is defined.
interface lzd48_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [47:0] req0_data;
   logic        req1_valid;
   logic        req1_ready;
   logic [47:0] req1_data;

   logic        res0_valid;
   logic        res0_ready;
   logic [5:0]  res0_cnt;
   logic        res0_zero;
   logic        res1_valid;
   logic        res1_ready;
   logic [5:0]  res1_cnt;
   logic        res1_zero;
`ifdef LZDARB_NORM_EN
   logic [47:0] res0_norm;
   logic [47:0] res1_norm;
`endif

   logic [47:0] lzd_a;
   logic [5:0]  lzd_p;
   logic        lzd_v;

   // master: requesters, result consumers and the shared detector
   modport master (
      output req0_valid, req0_data, req1_valid, req1_data,
      output res0_ready, res1_ready,
      output lzd_p, lzd_v,
      input  req0_ready, req1_ready,
      input  res0_valid, res0_cnt, res0_zero,
      input  res1_valid, res1_cnt, res1_zero,
`ifdef LZDARB_NORM_EN
      input  res0_norm, res1_norm,
`endif
      input  lzd_a
   );

   modport slave (
      input  req0_valid, req0_data, req1_valid, req1_data,
      input  res0_ready, res1_ready,
      input  lzd_p, lzd_v,
      output req0_ready, req1_ready,
      output res0_valid, res0_cnt, res0_zero,
      output res1_valid, res1_cnt, res1_zero,
`ifdef LZDARB_NORM_EN
      output res0_norm, res1_norm,
`endif
      output lzd_a
   );
endinterface

// File: rtl/lzd48_arbiter.sv
// Two-requester round-robin front end for a shared pipelined 48-bit leading-zero detector.
// Define LZDARB_NORM_EN to also return the normalized operand (res0_norm/res1_norm).
module lzd48_arbiter #(
   parameter int LZD_LAT    = 6,
   parameter int FIFO_DEPTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   lzd48_arbiter_if.slave bus
);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);

   logic [1:0]  req_valid;
   logic [47:0] req_data [2];
   logic [1:0]  res_ready;
   logic [1:0]  res_valid;
   logic [5:0]  res_cnt [2];
   logic [1:0]  res_zero;
   logic [1:0]  eligible;
   logic [1:0]  grant;
   logic        issue;
   logic        issue_id;
   logic        last_reg;
   logic [47:0] lzd_a_reg;

   assign req_valid   = {bus.req1_valid, bus.req0_valid};
   assign req_data[0] = bus.req0_data;
   assign req_data[1] = bus.req1_data;
   assign res_ready   = {bus.res1_ready, bus.res0_ready};

   // Round robin: on a conflict the requester that did not win last time goes.
   always_comb begin
      grant = eligible;
      if (&eligible) begin
         grant = last_reg ? 2'b01 : 2'b10;
      end
   end

   assign issue          = |grant;
   assign issue_id       = grant[1];
   assign bus.req0_ready = grant[0];
   assign bus.req1_ready = grant[1];
   assign bus.lzd_a      = lzd_a_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lzd_a_reg <= '0;
         last_reg  <= 1'b1;
      end else if (issue) begin
         lzd_a_reg <= req_data[issue_id];
         last_reg  <= issue_id;
      end
   end

   // Tag line: stage LZD_LAT lines up with the detector output for that operand.
   logic [LZD_LAT:0] tag_v_reg;
   logic [LZD_LAT:0] tag_id_reg;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_v_reg  <= '0;
         tag_id_reg <= '0;
      end else begin
         tag_v_reg  <= {tag_v_reg[LZD_LAT-1:0], issue};
         tag_id_reg <= {tag_id_reg[LZD_LAT-1:0], issue_id};
      end
   end

   logic       cap_v;
   logic       cap_id;
   logic [5:0] cap_cnt;
   logic       cap_zero;

   assign cap_v    = tag_v_reg[LZD_LAT];
   assign cap_id   = tag_id_reg[LZD_LAT];
   assign cap_cnt  = bus.lzd_v ? bus.lzd_p : 6'd48;
   assign cap_zero = !bus.lzd_v;

`ifdef LZDARB_NORM_EN
   logic [47:0] op_reg [LZD_LAT+1];
   logic [47:0] cap_norm;
   logic [47:0] res_norm [2];

   // Operand copy travels beside the tag; only entries with a valid tag are consumed.
   always_ff @(posedge clk) begin
      op_reg[0] <= req_data[issue_id];
      for (int i = 1; i <= LZD_LAT; i++) begin
         op_reg[i] <= op_reg[i-1];
      end
   end

   assign cap_norm      = op_reg[LZD_LAT] << cap_cnt;
   assign bus.res0_norm = res_norm[0];
   assign bus.res1_norm = res_norm[1];
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_res
         logic [5:0]    mem_cnt  [FIFO_DEPTH];
         logic          mem_zero [FIFO_DEPTH];
         logic [PW-1:0] wr_ptr_reg;
         logic [PW-1:0] rd_ptr_reg;
         logic [CW-1:0] count_reg;
         logic [CW-1:0] credit_reg;
         logic [CW-1:0] credit_next;
         logic          wr_en;
         logic          rd_en;

         assign wr_en         = cap_v && (cap_id == 1'(gi));
         assign rd_en         = res_valid[gi] && res_ready[gi];
         assign res_valid[gi] = (count_reg != '0);
         assign res_cnt[gi]   = res_valid[gi] ? mem_cnt[rd_ptr_reg] : 6'd0;
         assign res_zero[gi]  = res_valid[gi] ? mem_zero[rd_ptr_reg] : 1'b0;
         assign eligible[gi]  = rst_n && req_valid[gi] && (credit_reg != '0);

         always_ff @(posedge clk) begin
            if (wr_en) begin
               mem_cnt[wr_ptr_reg]  <= cap_cnt;
               mem_zero[wr_ptr_reg] <= cap_zero;
            end
         end

`ifdef LZDARB_NORM_EN
         logic [47:0] mem_norm [FIFO_DEPTH];

         always_ff @(posedge clk) begin
            if (wr_en) begin
               mem_norm[wr_ptr_reg] <= cap_norm;
            end
         end

         assign res_norm[gi] = res_valid[gi] ? mem_norm[rd_ptr_reg] : 48'd0;
`endif

         // A credit covers one slot from issue until its result is popped,
         // so the FIFO cannot be full when a result lands.
         always_comb begin
            credit_next = credit_reg;
            case ({grant[gi], rd_en})
               2'b10:   credit_next = credit_reg - CW'(1);
               2'b01:   credit_next = credit_reg + CW'(1);
               default: credit_next = credit_reg;
            endcase
         end

         always_ff @(posedge clk) begin
            if (!rst_n) begin
               wr_ptr_reg <= '0;
               rd_ptr_reg <= '0;
               count_reg  <= '0;
               credit_reg <= CW'(FIFO_DEPTH);
            end else begin
               credit_reg <= credit_next;
               if (wr_en) begin
                  wr_ptr_reg <= wr_ptr_reg + PW'(1);
               end
               if (rd_en) begin
                  rd_ptr_reg <= rd_ptr_reg + PW'(1);
               end
               case ({wr_en, rd_en})
                  2'b10:   count_reg <= count_reg + CW'(1);
                  2'b01:   count_reg <= count_reg - CW'(1);
                  default: count_reg <= count_reg;
               endcase
            end
         end
      end
   endgenerate

   assign bus.res0_valid = res_valid[0];
   assign bus.res1_valid = res_valid[1];
   assign bus.res0_cnt   = res_cnt[0];
   assign bus.res1_cnt   = res_cnt[1];
   assign bus.res0_zero  = res_zero[0];
   assign bus.res1_zero  = res_zero[1];
endmodule
